// File: rtl/wb_retire_if.sv
// Mem-to-writeback handshake: instruction payload from mem stage, allowin back from wb.
interface wb_retire_if #(
  parameter int unsigned DATA_W = 32
);
  logic              ms_valid;
  logic [DATA_W-1:0] ms_pc;
  logic [DATA_W-1:0] ms_result;
  logic              ms_gr_we;
  logic [4:0]        ms_dest;
  logic              ms_ex;
  logic [5:0]        ms_ecode;
  logic [8:0]        ms_esubcode;
  logic              ms_ertn;
  logic              ms_csr_re;
  logic              ms_csr_we;
  logic [13:0]       ms_csr_num;
  logic [DATA_W-1:0] ms_csr_wmask;
  logic [DATA_W-1:0] ms_csr_wvalue;
  logic              ws_allowin;

  modport master (
    output ms_valid, ms_pc, ms_result, ms_gr_we, ms_dest, ms_ex, ms_ecode, ms_esubcode,
           ms_ertn, ms_csr_re, ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue,
    input  ws_allowin
  );

  modport slave (
    input  ms_valid, ms_pc, ms_result, ms_gr_we, ms_dest, ms_ex, ms_ecode, ms_esubcode,
           ms_ertn, ms_csr_re, ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue,
    output ws_allowin
  );
endinterface

// File: rtl/wb_retire.sv
// Writeback/retire stage: holds one instruction, waits out CSR read latency,
// commits register/CSR writes, raises exception/ertn flushes and counts retirements.
module wb_retire #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CSR_RD_LAT = 1,
  parameter int unsigned CNT_W      = 64
) (
  input  logic              clk,
  input  logic              reset,
  wb_retire_if.slave        ms,
  output logic [13:0]       csr_num,
  output logic              csr_we,
  output logic [DATA_W-1:0] csr_wmask,
  output logic [DATA_W-1:0] csr_wvalue,
  input  logic [DATA_W-1:0] csr_rvalue,
  output logic              wb_ex,
  output logic              ertn_flush,
  output logic [5:0]        wb_ecode,
  output logic [8:0]        wb_esubcode,
  output logic [DATA_W-1:0] wb_epc,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_we,
  output logic [4:0]        fwd_dest,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_busy,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [DATA_W-1:0] debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
);

  localparam bit         HAS_WAIT  = (CSR_RD_LAT != 0);
  localparam logic [1:0] WAIT_LAST = 2'((CSR_RD_LAT == 0) ? 0 : CSR_RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] result;
    logic              gr_we;
    logic [4:0]        dest;
    logic              ex;
    logic [5:0]        ecode;
    logic [8:0]        esubcode;
    logic              ertn;
    logic              csr_re;
    logic              csr_we;
    logic [13:0]       csr_num;
    logic [DATA_W-1:0] csr_wmask;
    logic [DATA_W-1:0] csr_wvalue;
  } payload_t;

  state_t     state, state_nx;
  logic [1:0] wait_cnt, wait_cnt_nx;
  logic       ws_valid, ws_valid_nx;
  payload_t   ws;

  logic ws_ready_go, ws_allowin, commit, flush, accept;

  assign ws_ready_go   = (state != WAIT);
  assign ws_allowin    = !ws_valid | ws_ready_go;
  assign ms.ws_allowin = ws_allowin;
  assign commit        = ws_valid & ws_ready_go;
  assign flush         = commit & (ws.ex | ws.ertn);
  // A flushing commit drops whatever mem offers in the same cycle.
  assign accept        = ms.ms_valid & ws_allowin & !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 2'd0;
      ws_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      ws_valid <= ws_valid_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    ws_valid_nx = ws_valid;
    if (accept) begin
      ws_valid_nx = 1'b1;
      wait_cnt_nx = 2'd0;
      state_nx    = (ms.ms_csr_re & !ms.ms_ex & HAS_WAIT) ? WAIT : DONE;
    end else if (ws_allowin) begin
      ws_valid_nx = 1'b0;
      state_nx    = IDLE;
    end else begin
      wait_cnt_nx = wait_cnt + 2'd1;
      if (wait_cnt == WAIT_LAST) state_nx = DONE;
    end
  end

  // Payload carries no reset; every consumer is qualified by ws_valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      ws <= '{pc: ms.ms_pc, result: ms.ms_result, gr_we: ms.ms_gr_we, dest: ms.ms_dest,
              ex: ms.ms_ex, ecode: ms.ms_ecode, esubcode: ms.ms_esubcode, ertn: ms.ms_ertn,
              csr_re: ms.ms_csr_re, csr_we: ms.ms_csr_we, csr_num: ms.ms_csr_num,
              csr_wmask: ms.ms_csr_wmask, csr_wvalue: ms.ms_csr_wvalue};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 retire_cnt <= '0;
    else if (commit & !ws.ex)   retire_cnt <= retire_cnt + CNT_W'(1);
  end

  assign wb_ex       = commit & ws.ex;
  assign ertn_flush  = commit & ws.ertn & !ws.ex;
  assign wb_ecode    = wb_ex ? ws.ecode    : 6'd0;
  assign wb_esubcode = wb_ex ? ws.esubcode : 9'd0;
  assign wb_epc      = wb_ex ? ws.pc       : '0;

  assign rf_we    = commit & ws.gr_we & !ws.ex;
  assign rf_waddr = ws_valid ? ws.dest : 5'd0;
  assign rf_wdata = !ws_valid ? '0 : (ws.csr_re ? csr_rvalue : ws.result);

  assign csr_we     = commit & ws.csr_we & !ws.ex;
  assign csr_num    = ws_valid ? ws.csr_num    : 14'd0;
  assign csr_wmask  = ws_valid ? ws.csr_wmask  : '0;
  assign csr_wvalue = ws_valid ? ws.csr_wvalue : '0;

  // fwd_data is only meaningful once the CSR read has landed (fwd_busy low).
  assign fwd_we   = ws_valid & ws.gr_we;
  assign fwd_dest = ws_valid ? ws.dest : 5'd0;
  assign fwd_data = rf_wdata;
  assign fwd_busy = ws_valid & ws.csr_re & !ws_ready_go;

  assign debug_wb_pc       = ws_valid ? ws.pc : '0;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule
